bb_controller: RTL and testbench
================================

Name: bb_controller

Overview:
- Control unit for the BitBlaster 10-bit processor. It sits directly upstream of the ALU and the register file.
- Latches a 10-bit instruction and sequences it through timesteps T0..T3.
- Drives the ALU strobes (Ain, Gin, Gout, ALUcont) and the register-file and bus enables (Rin, Rout, ENW). Raises Done when the instruction retires.
- All state updates on the negative clock edge, matching the datapath registers.

Parameters:
- NREG, 4, number of general registers; width of the one-hot Rin/Rout vectors.
- IW, 10, instruction width.

Ports:
- CLKb  in  1  clock; all state updates on the falling edge.
- Clrb  in  1  asynchronous active-low reset.
- Run  in  1  start or continue execution; sampled in T0.
- INSTR  in  IW  instruction word from external memory; captured into internal IR at T0.
- IRin  out  1  IR load strobe (T0 while Run=1).
- Rin  out  NREG  one-hot register write enable.
- Rout  out  NREG  one-hot register bus-drive enable.
- ENW  out  1  external data (immediate / LD word) onto shared bus.
- Ain  out  1  ALU A-register load.
- Gin  out  1  ALU G-register load.
- Gout  out  1  ALU G onto bus.
- ALUcont  out  4  ALU function select (equals IR opcode).
- Done  out  1  instruction retire pulse, one cycle.
- Err  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- IR fields:
  - IR[9:8] = Rx (destination / first operand).
  - IR[7:6] = Ry (second operand).
  - IR[5:4] reserved, ignored.
  - IR[3:0] = opcode.
- Opcodes:
  - 0 LD
  - 1 COPY
  - 2 ADD
  - 3 SUB
  - 4 INV
  - 5 FLP
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 LSL
  - A LSR
  - B ASR
  - C ADDI
  - D SUBI
  - E, F illegal.
- State:
  - 2-bit step counter T0..T3 plus IR register.
  - Outputs are combinational decode of (step, IR, Run).
- Reset (Clrb=0, async):
  - step := T0, IR := 0, Err := 0.
  - All outputs forced 0 while Clrb=0, regardless of Run.
- Reset mid-instruction: aborts immediately; no Rin/Gin issued after reset asserts.
- T0:
  - Run=0: idle, all outputs 0, stay in T0.
  - Run=1: IRin=1; IR := INSTR at the falling edge; advance to T1.
- T1:
  - LD: ENW=1, Rin[Rx]=1, Done=1.
  - COPY: Rout[Ry]=1, Rin[Rx]=1, Done=1.
  - All ALU ops: Rout[Rx]=1, Ain=1.
- T2:
  - Binary register ops (ADD, SUB, AND, OR, XOR): Rout[Ry]=1, Gin=1, ALUcont=opcode.
  - Unary / shift ops (INV, FLP, LSL, LSR, ASR): Gin=1, ALUcont=opcode; bus not driven (OP don't-care).
  - ADDI/SUBI: ENW=1, Gin=1, ALUcont=opcode.
- T3 (all ALU ops): Gout=1, Rin[Rx]=1, Done=1.
- Step advance and return:
  - Done=1 clears the counter to T0 at the next falling edge.
  - Otherwise the counter increments.
  - Latency: LD/COPY 2 cycles, ALU ops 4 cycles.
- ALUcont is 0 in every step except T2. At most one bit of Rin and one bit of Rout is set.
- Run is sampled only in T0. Deasserting Run mid-instruction does not stall; the instruction completes.
- Rx=Ry is legal (e.g. ADD R1,R1): Rout and Rin selects are independent.
- Back-to-back: T0 of the next instruction immediately follows Done when Run=1.

Optional Feature:
- Macro: BB_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Opcode E/F in T1 sets sticky Err := 1; no strobes are issued.
  - The controller stays in T0, ignoring Run, until Clrb asserts.
- Undefined:
  - E/F execute as NOP: T1 asserts Done only; return to T0.
  - Err is tied 0.

Decomposition:
- Package bb_pkg:
  - opcode enum (4-bit, values above);
  - step enum T0..T3;
  - IR field bit-position constants;
  - NREG default.
- Sub-module bb_step_counter: 2-bit counter, negedge, async active-low reset, synchronous clear input, enable input.

Test Plan:
- Reset with Run=1, INSTR=0x002 -> all outputs 0 during reset; IRin=1 on the first cycle after release.
- LD R2 (INSTR=0x200) -> T0 IRin; T1 ENW=1, Rin=0100, Done=1; next cycle T0.
- ADD R1,R3 (0x1C2) -> T1 Rout=0010, Ain; T2 Rout=1000, Gin, ALUcont=2; T3 Gout, Rin=0010, Done.
- ADDI R0 (0x00C) -> T2 ENW=1, Gin, ALUcont=C, Rout=0000; Done at T3.
- Run dropped in T1 of SUB -> completes through T3; then idles in T0 with IRin=0.
- Opcode F (0x00F):
  - with macro: Err=1 and held; further Run ignored until reset.
  - without macro: Done in T1, Err=0.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared types and IR field layout for the BitBlaster control unit.
package bb_pkg;

  localparam int unsigned NREG_DEF = 4;
  localparam int unsigned IW_DEF   = 10;

  localparam int unsigned RX_LSB = 8;
  localparam int unsigned RY_LSB = 6;
  localparam int unsigned OP_LSB = 0;
  localparam int unsigned RW     = 2;
  localparam int unsigned OPW    = 4;

  typedef enum logic [3:0] {
    OP_LD    = 4'h0,
    OP_COPY  = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_INV   = 4'h4,
    OP_FLP   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_LSL   = 4'h9,
    OP_LSR   = 4'hA,
    OP_ASR   = 4'hB,
    OP_ADDI  = 4'hC,
    OP_SUBI  = 4'hD,
    OP_ILL_E = 4'hE,
    OP_ILL_F = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  function automatic logic is_alu(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SUBI);
  endfunction

  function automatic logic is_binary(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic is_imm(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_illegal(input opcode_t op);
    return (op == OP_ILL_E) || (op == OP_ILL_F);
  endfunction

endpackage

// File: rtl/bb_step_counter.sv
// 2-bit timestep counter on the falling edge; clear has priority over enable.
module bb_step_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] count
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 2'd1;
  end

endmodule

// File: rtl/bb_controller.sv
// BitBlaster control unit: latches IR in T0 and decodes strobes for T1..T3.
// Define BB_ILLEGAL_OP_TRAP_EN to trap opcodes E/F with a sticky Err.
module bb_controller
  import bb_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned IW   = IW_DEF
) (
  input  logic            CLKb,
  input  logic            Clrb,
  input  logic            Run,
  input  logic [IW-1:0]   INSTR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            ENW,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [3:0]      ALUcont,
  output logic            Done,
  output logic            Err
);

  logic [IW-1:0] ir;
  logic [1:0]    count;
  step_t         step;
  opcode_t       op;
  logic [RW-1:0] rx, ry;
  logic          err, trap, load, step_clr, step_en, done_int;
  logic          unused_ir;

  assign step      = step_t'(count);
  assign op        = opcode_t'(ir[OP_LSB +: OPW]);
  assign rx        = ir[RX_LSB +: RW];
  assign ry        = ir[RY_LSB +: RW];
  assign unused_ir = ^ir;

  function automatic logic [NREG-1:0] sel(input logic [RW-1:0] r);
    return NREG'(1) << r;
  endfunction

  bb_step_counter u_step (
    .clk   (CLKb),
    .rst_n (Clrb),
    .clr   (step_clr),
    .en    (step_en),
    .count (count)
  );

  always_ff @(negedge CLKb or negedge Clrb) begin
    if (!Clrb)     ir <= '0;
    else if (load) ir <= INSTR;
  end

`ifdef BB_ILLEGAL_OP_TRAP_EN
  assign trap = (step == T1) && is_illegal(op);

  always_ff @(negedge CLKb or negedge Clrb) begin
    if (!Clrb)     err <= 1'b0;
    else if (trap) err <= 1'b1;
  end
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  // Next step: T0 waits for Run (blocked once trapped); later steps advance until retire.
  always_comb begin
    load     = 1'b0;
    step_en  = 1'b0;
    step_clr = 1'b0;
    unique case (step)
      T0: begin
        load    = Run && !err;
        step_en = load;
      end
      default: begin
        step_clr = done_int || trap;
        step_en  = 1'b1;
      end
    endcase
  end

  // Everything is gated by Clrb so an async reset silences strobes before the counter settles.
  always_comb begin
    IRin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    ENW      = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    ALUcont  = '0;
    done_int = 1'b0;
    if (Clrb) begin
      unique case (step)
        T0: IRin = Run && !err;
        T1: begin
          if (op == OP_LD) begin
            ENW      = 1'b1;
            Rin      = sel(rx);
            done_int = 1'b1;
          end else if (op == OP_COPY) begin
            Rout     = sel(ry);
            Rin      = sel(rx);
            done_int = 1'b1;
          end else if (is_alu(op)) begin
            Rout = sel(rx);
            Ain  = 1'b1;
          end else if (!trap) begin
            done_int = 1'b1;
          end
        end
        T2: begin
          Gin     = 1'b1;
          ALUcont = ir[OP_LSB +: OPW];
          if (is_binary(op))   Rout = sel(ry);
          else if (is_imm(op)) ENW  = 1'b1;
        end
        T3: begin
          Gout     = 1'b1;
          Rin      = sel(rx);
          done_int = 1'b1;
        end
      endcase
    end
  end

  assign Done = done_int;
  assign Err  = err;

endmodule

// File: tb/tb_bb_controller.sv
// Directed self-checking bench for bb_controller; outputs sampled on the rising edge.
module tb_bb_controller;

  logic       CLKb = 1'b1;
  logic       Clrb;
  logic       Run;
  logic [9:0] INSTR;
  logic       IRin, ENW, Ain, Gin, Gout, Done, Err;
  logic [3:0] Rin, Rout, ALUcont;
  logic [18:0] outs;

  int checks = 0;
  int errors = 0;

  bb_controller #(.NREG(4), .IW(10)) dut (
    .CLKb    (CLKb),
    .Clrb    (Clrb),
    .Run     (Run),
    .INSTR   (INSTR),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .ENW     (ENW),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .ALUcont (ALUcont),
    .Done    (Done),
    .Err     (Err)
  );

  always #5 CLKb = ~CLKb;

  assign outs = {IRin, Rin, Rout, ENW, Ain, Gin, Gout, ALUcont, Done, Err};

  function automatic logic [18:0] pack(input logic irin, input logic [3:0] rin,
                                       input logic [3:0] rout, input logic enw,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic [3:0] aluc, input logic done,
                                       input logic err);
    return {irin, rin, rout, enw, ain, gin, gout, aluc, done, err};
  endfunction

  localparam logic [18:0] ZERO = '0;

  task automatic test_reset();
    Clrb = 1'b0; Run = 1'b1; INSTR = 10'h002;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLKb);
      checks++;
      if (outs !== ZERO) begin errors++; $display("FAIL reset_hold cyc %0d: got %h want %h", i, outs, ZERO); end
      @(negedge CLKb); #1;
    end
    Clrb = 1'b1;
    @(posedge CLKb);
    checks++;
    if (outs !== pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0)) begin
      errors++; $display("FAIL reset_release_irin: got %h want %h", outs, pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0));
    end
    @(negedge CLKb); #1;
    Run = 1'b0;
    @(posedge CLKb);
    checks++;
    if (outs !== pack(0,4'b0,4'b0001,0,1,0,0,4'h0,0,0)) begin
      errors++; $display("FAIL reset_add_t1: got %h want %h", outs, pack(0,4'b0,4'b0001,0,1,0,0,4'h0,0,0));
    end
    #1 Clrb = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO) begin errors++; $display("FAIL reset_abort_async: got %h want %h", outs, ZERO); end
    @(negedge CLKb); #1;
    @(posedge CLKb);
    checks++;
    if (outs !== ZERO) begin errors++; $display("FAIL reset_abort_hold: got %h want %h", outs, ZERO); end
    @(negedge CLKb); #1;
    Clrb = 1'b1;
    @(posedge CLKb);
    checks++;
    if (outs !== ZERO) begin errors++; $display("FAIL reset_abort_idle: got %h want %h", outs, ZERO); end
    @(negedge CLKb); #1;
  endtask

  task automatic test_ld();
    logic        r [3];
    logic [18:0] e [3];
    r = '{1'b1, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0100,4'b0,1,0,0,0,4'h0,1,0),
          ZERO};
    INSTR = 10'h200;
    for (int i = 0; i < 3; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL ld cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_add();
    logic        r [5];
    logic [18:0] e [5];
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0010,0,1,0,0,4'h0,0,0),
          pack(0,4'b0,4'b1000,0,0,1,0,4'h2,0,0),
          pack(0,4'b0010,4'b0,0,0,0,1,4'h0,1,0),
          ZERO};
    INSTR = 10'h1C2;
    for (int i = 0; i < 5; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL add cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_addi();
    logic        r [5];
    logic [18:0] e [5];
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0001,0,1,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0,1,0,1,0,4'hC,0,0),
          pack(0,4'b0001,4'b0,0,0,0,1,4'h0,1,0),
          ZERO};
    INSTR = 10'h00C;
    for (int i = 0; i < 5; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL addi cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_run_drop();
    logic        r [6];
    logic [18:0] e [6];
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0100,0,1,0,0,4'h0,0,0),
          pack(0,4'b0,4'b1000,0,0,1,0,4'h3,0,0),
          pack(0,4'b0100,4'b0,0,0,0,1,4'h0,1,0),
          ZERO,
          ZERO};
    INSTR = 10'h2C3;
    for (int i = 0; i < 6; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL run_drop cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic        r [5];
    logic [9:0]  ins [5];
    logic [18:0] e [5];
    r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ins = '{10'h341, 10'h100, 10'h100, 10'h100, 10'h100};
    e   = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
            pack(0,4'b1000,4'b0010,0,0,0,0,4'h0,1,0),
            pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
            pack(0,4'b0010,4'b0,1,0,0,0,4'h0,1,0),
            ZERO};
    for (int i = 0; i < 5; i++) begin
      Run = r[i]; INSTR = ins[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL b2b cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_same_reg();
    logic        r [5];
    logic [18:0] e [5];
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0010,0,1,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0010,0,0,1,0,4'h2,0,0),
          pack(0,4'b0010,4'b0,0,0,0,1,4'h0,1,0),
          ZERO};
    INSTR = 10'h142;
    for (int i = 0; i < 5; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL same_reg cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_unary();
    logic        r [5];
    logic [18:0] e [5];
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0100,0,1,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0,0,0,1,0,4'h4,0,0),
          pack(0,4'b0100,4'b0,0,0,0,1,4'h0,1,0),
          ZERO};
    INSTR = 10'h204;
    for (int i = 0; i < 5; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL unary cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
  endtask

  task automatic test_illegal();
    logic        r [4];
    logic [18:0] e [4];
`ifdef BB_ILLEGAL_OP_TRAP_EN
    r = '{1'b1, 1'b1, 1'b1, 1'b1};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          ZERO,
          pack(0,4'b0,4'b0,0,0,0,0,4'h0,0,1),
          pack(0,4'b0,4'b0,0,0,0,0,4'h0,0,1)};
`else
    r = '{1'b1, 1'b0, 1'b1, 1'b0};
    e = '{pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0,0,0,0,0,4'h0,1,0),
          pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0),
          pack(0,4'b0,4'b0,0,0,0,0,4'h0,1,0)};
`endif
    INSTR = 10'h00F;
    for (int i = 0; i < 4; i++) begin
      Run = r[i];
      @(posedge CLKb);
      checks++;
      if (outs !== e[i]) begin errors++; $display("FAIL illegal cyc %0d: got %h want %h", i, outs, e[i]); end
      @(negedge CLKb); #1;
    end
    Run = 1'b0;
    Clrb = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO) begin errors++; $display("FAIL illegal_reset: got %h want %h", outs, ZERO); end
    @(negedge CLKb); #1;
    Clrb = 1'b1; Run = 1'b1;
    @(posedge CLKb);
    checks++;
    if (outs !== pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0)) begin
      errors++; $display("FAIL illegal_recover: got %h want %h", outs, pack(1,4'b0,4'b0,0,0,0,0,4'h0,0,0));
    end
    #1 Run = 1'b0;
    @(negedge CLKb); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ld();
    test_add();
    test_addi();
    test_run_drop();
    test_back_to_back();
    test_same_reg();
    test_unary();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
